multdiv_seq: RTL and testbench

Iterative signed 32-bit multiply/divide unit for the game CPU's execute stage. It accepts a one-cycle start pulse, iterates one bit per clock, then presents a registered result with a one-cycle ready strobe. That result is written into the processor's 32-bit result register (clock, write-enable, async clear). The block holds its last result stable, so the downstream register can capture it on the ready strobe or later.

---
 rtl/multdiv_seq.sv | 146 ++++++++++++++
 tb/tb_multdiv_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide: one bit per clock, WIDTH+1 edge latency.
// Optional macro MULTDIV_DIV_EN builds the restoring divider datapath.
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [W2-1:0]     acc;
  logic [WIDTH-1:0]  mag;
  logic              neg;
  logic              is_div;

  logic              start;
  logic [WIDTH-1:0]  abs_a;
  logic [WIDTH-1:0]  abs_b;
  logic [WIDTH:0]    msum;
  logic [W2-1:0]     mstep;
  logic [W2-1:0]     prod;
  logic [WIDTH-1:0]  fin_res;
  logic              fin_exc;

  assign start = ctrl_MULT | ctrl_DIV;
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign busy  = (state != IDLE);

  // Shift-add: add multiplicand into the high half when the low bit is set.
  assign msum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
  assign mstep = {msum, acc[WIDTH-1:1]};
  assign prod  = neg ? -acc : acc;

`ifdef MULTDIV_DIV_EN
  logic              bzero;
  logic              ovf;
  logic [W2-1:0]     shl;
  logic [WIDTH:0]    dif;
  logic [W2-1:0]     dstep;
  logic [WIDTH-1:0]  quot;

  // Restoring step: shift left, keep the trial subtraction if it stays non-negative.
  assign shl   = {acc[W2-2:0], 1'b0};
  assign dif   = {1'b0, shl[W2-1:WIDTH]} - {1'b0, mag};
  assign dstep = dif[WIDTH] ? shl : {dif[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
  assign quot  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
`endif

  // Final signed result and exception from the finished accumulator.
  always_comb begin
    fin_res = prod[WIDTH-1:0];
    fin_exc = prod[W2-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
    if (is_div) begin
`ifdef MULTDIV_DIV_EN
      if (bzero) begin
        fin_res = '0;
        fin_exc = 1'b1;
      end else if (ovf) begin
        fin_res = MIN;
        fin_exc = 1'b1;
      end else begin
        fin_res = quot;
        fin_exc = 1'b0;
      end
`else
      fin_res = '0;
      fin_exc = 1'b1;
`endif
    end
  end

  // Control FSM, datapath iteration and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= '0;
      mag            <= '0;
      neg            <= 1'b0;
      is_div         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef MULTDIV_DIV_EN
      bzero          <= 1'b0;
      ovf            <= 1'b0;
`endif
    end else begin
      data_resultRDY <= 1'b0;
      unique case (state)
        IDLE: ;
        RUN: begin
`ifdef MULTDIV_DIV_EN
          acc <= is_div ? dstep : mstep;
`else
          if (!is_div) acc <= mstep;
`endif
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          data_result    <= fin_res;
          data_exception <= fin_exc;
          data_resultRDY <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A start overrides whatever is in flight; multiply wins a tie.
      if (start) begin
        state  <= RUN;
        cnt    <= '0;
        is_div <= !ctrl_MULT;
        neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        if (ctrl_MULT) begin
          mag <= abs_a;
          acc <= {{WIDTH{1'b0}}, abs_b};
        end else begin
          mag <= abs_b;
          acc <= {{WIDTH{1'b0}}, abs_a};
        end
`ifdef MULTDIV_DIV_EN
        bzero <= (data_operandB == '0);
        ovf   <= (data_operandA == MIN) && (data_operandB == '1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq.
// Divide expectations follow MULTDIV_DIV_EN as the RTL is built.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int pass_cnt = 0;
  int total    = 0;

  multdiv_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Pulse a start across one rising edge (E0); scramble operands afterwards.
  task automatic start_op(input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1357_9BDF;
  endtask

  // Run one operation and collect what the DUT shows at E1..E34.
  task automatic run_op(input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc,
                        output logic early, output logic rdy,
                        output logic late);
    start_op(m, d, a, b);
    early = 1'b0;
    repeat (32) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early = 1'b1;
    end
    @(posedge clock);
    #1;
    res = data_result;
    exc = data_exception;
    rdy = data_resultRDY;
    @(posedge clock);
    #1;
    late = data_resultRDY | busy;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0)
      $display("FAIL reset_outputs got res=%h exc=%b rdy=%b busy=%b want 0",
               data_result, data_exception, data_resultRDY, busy);
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic check_op(input string name,
                          input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want_res, input logic want_exc);
    logic [31:0] res;
    logic exc, early, rdy, late;
    run_op(m, d, a, b, res, exc, early, rdy, late);
    total++;
    if (res !== want_res || exc !== want_exc)
      $display("FAIL %s result got %h/%b want %h/%b",
               name, res, exc, want_res, want_exc);
    else pass_cnt++;
    total++;
    if (early !== 1'b0 || rdy !== 1'b1 || late !== 1'b0)
      $display("FAIL %s timing got early=%b rdy@E33=%b after=%b want 0/1/0",
               name, early, rdy, late);
    else pass_cnt++;
  endtask

  task automatic test_mult;
    check_op("mult_7x-6", 1'b1, 1'b0, 32'd7, -32'sd6, 32'hFFFF_FFD6, 1'b0);
    check_op("mult_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000,
             32'h0000_0000, 1'b1);
    check_op("mult_neg_neg", 1'b1, 1'b0, -32'sd3, -32'sd5, 32'd15, 1'b0);
  endtask

  task automatic test_div;
`ifdef MULTDIV_DIV_EN
    check_op("div_-17/5", 1'b0, 1'b1, -32'sd17, 32'd5, 32'hFFFF_FFFD, 1'b0);
    check_op("div_by_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
    check_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
             32'h8000_0000, 1'b1);
    check_op("div_10/2", 1'b0, 1'b1, 32'd10, 32'd2, 32'd5, 1'b0);
`else
    check_op("div_-17/5", 1'b0, 1'b1, -32'sd17, 32'd5, 32'd0, 1'b1);
    check_op("div_by_0", 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
    check_op("div_10/2", 1'b0, 1'b1, 32'd10, 32'd2, 32'd0, 1'b1);
`endif
  endtask

  task automatic test_abort;
    logic early;
    logic [31:0] want_res;
    logic want_exc;
`ifdef MULTDIV_DIV_EN
    want_res = 32'd14;
    want_exc = 1'b0;
`else
    want_res = 32'd0;
    want_exc = 1'b1;
`endif
    early = 1'b0;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early = 1'b1;
    end
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    if (data_resultRDY) early = 1'b1;
    repeat (32) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early = 1'b1;
    end
    total++;
    if (early !== 1'b0)
      $display("FAIL abort_no_strobe got strobe=%b want 0", early);
    else pass_cnt++;
    @(posedge clock);
    #1;
    total++;
    if (data_resultRDY !== 1'b1 || data_result !== want_res ||
        data_exception !== want_exc)
      $display("FAIL abort_restart got rdy=%b %h/%b want 1 %h/%b",
               data_resultRDY, data_result, data_exception,
               want_res, want_exc);
    else pass_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back;
    logic early;
    early = 1'b0;
    start_op(1'b1, 1'b0, 32'd7, -32'sd6);
    repeat (32) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early = 1'b1;
    end
    ctrl_MULT = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    total++;
    if (data_resultRDY !== 1'b1 || data_result !== 32'hFFFF_FFD6 ||
        busy !== 1'b1 || early !== 1'b0)
      $display("FAIL b2b_first got rdy=%b res=%h busy=%b early=%b want 1 ffffffd6 1 0",
               data_resultRDY, data_result, busy, early);
    else pass_cnt++;
    repeat (32) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early = 1'b1;
    end
    @(posedge clock);
    #1;
    total++;
    if (data_resultRDY !== 1'b1 || data_result !== 32'd25 || early !== 1'b0)
      $display("FAIL b2b_second got rdy=%b res=%h early=%b want 1 00000019 0",
               data_resultRDY, data_result, early);
    else pass_cnt++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    start_op(1'b1, 1'b0, 32'h1234, 32'h10);
    repeat (19) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0)
      $display("FAIL reset_mid_clear got res=%h exc=%b rdy=%b busy=%b want 0",
               data_result, data_exception, data_resultRDY, busy);
    else pass_cnt++;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0)
      $display("FAIL reset_mid_idle got activity=%b want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_both;
    check_op("mult_wins", 1'b1, 1'b1, 32'd2, 32'd3, 32'd6, 1'b0);
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    test_both;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
